// File: rtl/reg_fetch_fwd.sv
// Register-fetch / forward stage for the SimpleFixed2 execution pipe.
// Holds the SPU register file, reads RA/RB with same-cycle write-back
// bypass, and registers the instruction bundle for the execution unit.
// While stalled, the held bundle keeps listening to write-back so its
// operands never go stale.
module reg_fetch_fwd #(
    parameter int NREGS = 128,
    parameter int WIDTH = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       op_dec,
    input  logic [2:0]        format_dec,
    input  logic [6:0]        rt_addr_dec,
    input  logic [6:0]        ra_addr,
    input  logic [6:0]        rb_addr,
    input  logic [17:0]       imm_dec,
    input  logic              reg_write_dec,
    input  logic              stall,
    input  logic              flush,
    input  logic [WIDTH-1:0]  rt_wb,
    input  logic [6:0]        rt_addr_wb,
    input  logic              reg_write_wb,
    output logic [10:0]       op,
    output logic [2:0]        format,
    output logic [6:0]        rt_addr,
    output logic [WIDTH-1:0]  ra,
    output logic [WIDTH-1:0]  rb,
    output logic [17:0]       imm,
    output logic              reg_write
);

    logic [WIDTH-1:0] regs_q [NREGS];

    logic [10:0]      op_q, op_d;
    logic [2:0]       format_q, format_d;
    logic [6:0]       rt_addr_q, rt_addr_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [17:0]      imm_q, imm_d;
    logic             reg_write_q, reg_write_d;
    logic [6:0]       ra_hold_q, ra_hold_d;
    logic [6:0]       rb_hold_q, rb_hold_d;

    logic [WIDTH-1:0] opa_byp, opb_byp;

    // Register file: cleared on reset, written by the write-back bus otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_write_wb) begin
            regs_q[rt_addr_wb] <= rt_wb;
        end
    end

    // Operand read with same-cycle write-back bypass.
    always_comb begin
        opa_byp = regs_q[ra_addr];
        opb_byp = regs_q[rb_addr];
        if (reg_write_wb && (rt_addr_wb == ra_addr)) opa_byp = rt_wb;
        if (reg_write_wb && (rt_addr_wb == rb_addr)) opb_byp = rt_wb;
    end

    // Next bundle: flush beats stall beats load; a stalled bundle re-forwards
    // write-back data that targets its held source addresses.
    always_comb begin
        op_d        = op_q;
        format_d    = format_q;
        rt_addr_d   = rt_addr_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        imm_d       = imm_q;
        reg_write_d = reg_write_q;
        ra_hold_d   = ra_hold_q;
        rb_hold_d   = rb_hold_q;
        if (flush) begin
            op_d        = '0;
            format_d    = '0;
            rt_addr_d   = '0;
            ra_d        = '0;
            rb_d        = '0;
            imm_d       = '0;
            reg_write_d = 1'b0;
        end else if (stall) begin
            if (reg_write_wb && (rt_addr_wb == ra_hold_q)) ra_d = rt_wb;
            if (reg_write_wb && (rt_addr_wb == rb_hold_q)) rb_d = rt_wb;
        end else begin
            op_d        = op_dec;
            format_d    = format_dec;
            rt_addr_d   = rt_addr_dec;
            ra_d        = opa_byp;
            rb_d        = opb_byp;
            imm_d       = imm_dec;
            reg_write_d = reg_write_dec;
            ra_hold_d   = ra_addr;
            rb_hold_d   = rb_addr;
        end
    end

    // Bundle and held-address registers; reset has top priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= '0;
            format_q    <= '0;
            rt_addr_q   <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            imm_q       <= '0;
            reg_write_q <= 1'b0;
            ra_hold_q   <= '0;
            rb_hold_q   <= '0;
        end else begin
            op_q        <= op_d;
            format_q    <= format_d;
            rt_addr_q   <= rt_addr_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            imm_q       <= imm_d;
            reg_write_q <= reg_write_d;
            ra_hold_q   <= ra_hold_d;
            rb_hold_q   <= rb_hold_d;
        end
    end

    assign op        = op_q;
    assign format    = format_q;
    assign rt_addr   = rt_addr_q;
    assign ra        = ra_q;
    assign rb        = rb_q;
    assign imm       = imm_q;
    assign reg_write = reg_write_q;

endmodule

// File: tb/tb_reg_fetch_fwd.sv
// Bench for reg_fetch_fwd: directed vector table applied one per cycle,
// plus hand-written reset sequences.
module tb_reg_fetch_fwd;

    localparam int W = 128;
    localparam logic [W-1:0] ZR = '0;
    localparam logic [W-1:0] P1 = {8{16'h0001}};
    localparam logic [W-1:0] P2 = {8{16'h5555}};
    localparam logic [W-1:0] PA = {8{16'hAAAA}};
    localparam logic [W-1:0] PB = {8{16'h1234}};

    logic          clk;
    logic          reset;
    logic [10:0]   op_dec;
    logic [2:0]    format_dec;
    logic [6:0]    rt_addr_dec;
    logic [6:0]    ra_addr;
    logic [6:0]    rb_addr;
    logic [17:0]   imm_dec;
    logic          reg_write_dec;
    logic          stall;
    logic          flush;
    logic [W-1:0]  rt_wb;
    logic [6:0]    rt_addr_wb;
    logic          reg_write_wb;
    logic [10:0]   op;
    logic [2:0]    format;
    logic [6:0]    rt_addr;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic [17:0]   imm;
    logic          reg_write;

    typedef struct {
        logic          stall;
        logic          flush;
        logic [10:0]   op;
        logic [2:0]    fmt;
        logic [6:0]    rt;
        logic [6:0]    ra_a;
        logic [6:0]    rb_a;
        logic [17:0]   imm;
        logic          rw;
        logic          wb_en;
        logic [6:0]    wb_addr;
        logic [W-1:0]  wb_data;
        logic [10:0]   e_op;
        logic [2:0]    e_fmt;
        logic [6:0]    e_rt;
        logic [W-1:0]  e_ra;
        logic [W-1:0]  e_rb;
        logic [17:0]   e_imm;
        logic          e_rw;
    } vec_t;

    localparam int NV = 12;
    vec_t vec [NV];

    logic [W-1:0] exp_q [$];
    int checks;
    int failures;

    reg_fetch_fwd dut (
        .clk           (clk),
        .reset         (reset),
        .op_dec        (op_dec),
        .format_dec    (format_dec),
        .rt_addr_dec   (rt_addr_dec),
        .ra_addr       (ra_addr),
        .rb_addr       (rb_addr),
        .imm_dec       (imm_dec),
        .reg_write_dec (reg_write_dec),
        .stall         (stall),
        .flush         (flush),
        .rt_wb         (rt_wb),
        .rt_addr_wb    (rt_addr_wb),
        .reg_write_wb  (reg_write_wb),
        .op            (op),
        .format        (format),
        .rt_addr       (rt_addr),
        .ra            (ra),
        .rb            (rb),
        .imm           (imm),
        .reg_write     (reg_write)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall         = v.stall;
        flush         = v.flush;
        op_dec        = v.op;
        format_dec    = v.fmt;
        rt_addr_dec   = v.rt;
        ra_addr       = v.ra_a;
        rb_addr       = v.rb_a;
        imm_dec       = v.imm;
        reg_write_dec = v.rw;
        reg_write_wb  = v.wb_en;
        rt_addr_wb    = v.wb_addr;
        rt_wb         = v.wb_data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: operands come from exp_q, control fields from arguments.
    task automatic check_bundle(input string tag, input logic [10:0] e_op, input logic [2:0] e_fmt,
                                input logic [6:0] e_rt, input logic [17:0] e_imm, input logic e_rw);
        logic [W-1:0] e_ra;
        logic [W-1:0] e_rb;
        e_ra = exp_q.pop_front();
        e_rb = exp_q.pop_front();
        check({tag, ".op"},        W'(op),        W'(e_op));
        check({tag, ".format"},    W'(format),    W'(e_fmt));
        check({tag, ".rt_addr"},   W'(rt_addr),   W'(e_rt));
        check({tag, ".ra"},        ra,            e_ra);
        check({tag, ".rb"},        rb,            e_rb);
        check({tag, ".imm"},       W'(imm),       W'(e_imm));
        check({tag, ".reg_write"}, W'(reg_write), W'(e_rw));
    endtask

    task automatic idle_inputs();
        vec_t v;
        v = '{1'b0, 1'b0, 11'h0, 3'd0, 7'd0, 7'd0, 7'd0, 18'h0, 1'b0, 1'b0, 7'd0, ZR,
              11'h0, 3'd0, 7'd0, ZR, ZR, 18'h0, 1'b0};
        drive(v);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vec[0]  = '{1'b0, 1'b0, 11'h05F, 3'd1, 7'd10, 7'd3, 7'd4, 18'd5, 1'b1, 1'b0, 7'd0, ZR,
                    11'h05F, 3'd1, 7'd10, ZR, ZR, 18'd5, 1'b1};
        vec[1]  = '{1'b0, 1'b0, 11'h000, 3'd0, 7'd0, 7'd0, 7'd0, 18'd0, 1'b0, 1'b1, 7'd5, P1,
                    11'h000, 3'd0, 7'd0, ZR, ZR, 18'd0, 1'b0};
        vec[2]  = '{1'b0, 1'b0, 11'h010, 3'd0, 7'd0, 7'd5, 7'd6, 18'd0, 1'b0, 1'b0, 7'd0, ZR,
                    11'h010, 3'd0, 7'd0, P1, ZR, 18'd0, 1'b0};
        vec[3]  = '{1'b0, 1'b0, 11'h011, 3'd0, 7'd0, 7'd7, 7'd7, 18'd0, 1'b0, 1'b1, 7'd7, PA,
                    11'h011, 3'd0, 7'd0, PA, PA, 18'd0, 1'b0};
        vec[4]  = '{1'b0, 1'b0, 11'h012, 3'd0, 7'd0, 7'd7, 7'd5, 18'd0, 1'b0, 1'b0, 7'd0, ZR,
                    11'h012, 3'd0, 7'd0, PA, P1, 18'd0, 1'b0};
        vec[5]  = '{1'b0, 1'b0, 11'h020, 3'd7, 7'd3, 7'd9, 7'd5, 18'h3FFFF, 1'b1, 1'b0, 7'd0, ZR,
                    11'h020, 3'd7, 7'd3, ZR, P1, 18'h3FFFF, 1'b1};
        vec[6]  = '{1'b1, 1'b0, 11'h7FF, 3'd2, 7'd1, 7'd1, 7'd1, 18'd1, 1'b0, 1'b1, 7'd9, PB,
                    11'h020, 3'd7, 7'd3, PB, P1, 18'h3FFFF, 1'b1};
        vec[7]  = '{1'b1, 1'b0, 11'h7FF, 3'd2, 7'd1, 7'd1, 7'd1, 18'd1, 1'b0, 1'b1, 7'd5, P2,
                    11'h020, 3'd7, 7'd3, PB, P2, 18'h3FFFF, 1'b1};
        vec[8]  = '{1'b1, 1'b1, 11'h7FF, 3'd2, 7'd1, 7'd1, 7'd1, 18'd1, 1'b1, 1'b0, 7'd0, ZR,
                    11'h000, 3'd0, 7'd0, ZR, ZR, 18'd0, 1'b0};
        vec[9]  = '{1'b0, 1'b0, 11'h030, 3'd2, 7'd4, 7'd9, 7'd5, 18'd1, 1'b1, 1'b0, 7'd0, ZR,
                    11'h030, 3'd2, 7'd4, PB, P2, 18'd1, 1'b1};
        vec[10] = '{1'b0, 1'b0, 11'h031, 3'd3, 7'd4, 7'd4, 7'd9, 18'd2, 1'b1, 1'b1, 7'd4, PA,
                    11'h031, 3'd3, 7'd4, PA, PB, 18'd2, 1'b1};
        vec[11] = '{1'b1, 1'b0, 11'h055, 3'd5, 7'd6, 7'd3, 7'd3, 18'd3, 1'b0, 1'b1, 7'd3, P1,
                    11'h031, 3'd3, 7'd4, PA, PB, 18'd2, 1'b1};

        // Reset: two cycles, then the bundle must be all zero.
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        exp_q.push_back(ZR);
        exp_q.push_back(ZR);
        check_bundle("reset", 11'h0, 3'd0, 7'd0, 18'h0, 1'b0);
        reset = 1'b0;

        // Directed vectors, one per cycle.
        for (int i = 0; i < NV; i++) begin
            drive(vec[i]);
            exp_q.push_back(vec[i].e_ra);
            exp_q.push_back(vec[i].e_rb);
            tick();
            check_bundle($sformatf("vec%0d", i), vec[i].e_op, vec[i].e_fmt, vec[i].e_rt,
                         vec[i].e_imm, vec[i].e_rw);
        end

        // Reset mid-stall with a write-back to reg 2 in flight: write is discarded.
        reset        = 1'b1;
        stall        = 1'b1;
        flush        = 1'b0;
        reg_write_wb = 1'b1;
        rt_addr_wb   = 7'd2;
        rt_wb        = P1;
        tick();
        exp_q.push_back(ZR);
        exp_q.push_back(ZR);
        check_bundle("rst_stall", 11'h0, 3'd0, 7'd0, 18'h0, 1'b0);

        // After reset, reg 2 and reg 4 (written earlier) both read as zero.
        reset = 1'b0;
        idle_inputs();
        op_dec        = 11'h040;
        format_dec    = 3'd4;
        rt_addr_dec   = 7'd8;
        ra_addr       = 7'd2;
        rb_addr       = 7'd4;
        imm_dec       = 18'h00ABC;
        reg_write_dec = 1'b1;
        tick();
        exp_q.push_back(ZR);
        exp_q.push_back(ZR);
        check_bundle("post_rst", 11'h040, 3'd4, 7'd8, 18'h00ABC, 1'b1);

        // Stalled bundle with ra==rb held address: one write-back updates both.
        idle_inputs();
        stall        = 1'b0;
        op_dec       = 11'h041;
        ra_addr      = 7'd12;
        rb_addr      = 7'd12;
        tick();
        stall        = 1'b1;
        reg_write_wb = 1'b1;
        rt_addr_wb   = 7'd12;
        rt_wb        = P2;
        tick();
        exp_q.push_back(P2);
        exp_q.push_back(P2);
        check_bundle("stall_both", 11'h041, 3'd0, 7'd0, 18'h0, 1'b0);

        idle_inputs();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
